// File: rtl/move_event_gen_pkg.sv
// Shared definitions for the move event generator: FSM state encoding and
// the direction channel indices used by the player logic.
package move_event_gen_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HOLD_DELAY  = 2'd1,
    HOLD_REPEAT = 2'd2,
    WAIT_REL    = 2'd3
  } state_t;

  localparam int LEFT  = 0;
  localparam int DOWN  = 1;
  localparam int UP    = 2;
  localparam int RIGHT = 3;

endpackage

// File: rtl/move_event_gen_sync_edge_n.sv
// Two-flop synchroniser for a bundle of asynchronous inputs plus a registered
// rising-edge detector for the level vector derived from them.
// The edge detector is held "all previously high" until the synchroniser has
// refilled after reset, so a key held through reset never looks like a new
// press; it has to be released and pressed again.
module sync_edge_n #(
  parameter int                SYNC_W   = 8,
  parameter int                EDGE_W   = 4,
  parameter logic [SYNC_W-1:0] SYNC_RST = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [SYNC_W-1:0] din,
  output logic [SYNC_W-1:0] sync,
  input  logic [EDGE_W-1:0] lvl,
  output logic [EDGE_W-1:0] rise
);

  logic [SYNC_W-1:0] meta;
  logic [1:0]        settle;
  logic [EDGE_W-1:0] lvl_q;

  // Two-stage synchroniser, resetting to the released state of each input
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= SYNC_RST;
      sync <= SYNC_RST;
    end else begin
      meta <= din;
      sync <= meta;
    end
  end

  // Previous-level register, masked high until the synchroniser output is trustworthy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      settle <= 2'b00;
      lvl_q  <= '1;
    end else begin
      settle <= {settle[0], 1'b1};
      lvl_q  <= settle[1] ? lvl : '1;
    end
  end

  assign rise = lvl & ~lvl_q;

endmodule

// File: rtl/move_event_gen.sv
// Merges keyboard levels and active-low buttons into a stream of one-hot
// move events with hold-to-repeat, delivered through a one-entry
// valid/ready buffer. Events that arrive while the buffer is blocked are
// counted in a saturating drop counter.
module move_event_gen
  import move_event_gen_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int CNT_W         = 16,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100,
  parameter int REPEAT_EN     = 1,
  parameter int DROP_W        = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              tick_en,
  input  logic [N_CH-1:0]   kbd_in,
  input  logic [N_CH-1:0]   btn_in,
  input  logic [N_CH-1:0]   ch_mask,
  output logic              evt_valid,
  output logic [N_CH-1:0]   evt_dir,
  input  logic              evt_ready,
  output logic              active,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam state_t HOLD_ENTRY = (REPEAT_EN != 0) ? HOLD_DELAY : WAIT_REL;

  logic [2*N_CH-1:0] sync_all;
  logic [N_CH-1:0]   kbd_sync, btn_sync, lvl, new_press, other_press, cur_onehot;
  logic [CH_W-1:0]   cur_ch, next_ch, sel_ch;
  logic [CNT_W-1:0]  cnt, cnt_adv, cnt_next;
  state_t            state, next_state;
  logic              emit, accept;

  sync_edge_n #(
    .SYNC_W   (2*N_CH),
    .EDGE_W   (N_CH),
    .SYNC_RST ({{N_CH{1'b1}}, {N_CH{1'b0}}})
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .din  ({btn_in, kbd_in}),
    .sync (sync_all),
    .lvl  (lvl),
    .rise (new_press)
  );

  assign kbd_sync    = sync_all[N_CH-1:0];
  assign btn_sync    = sync_all[2*N_CH-1:N_CH];
  assign lvl         = (kbd_sync | ~btn_sync) & ch_mask;
  assign cur_onehot  = N_CH'(1) << cur_ch;
  assign other_press = new_press & ~((state == IDLE) ? '0 : cur_onehot);
  assign cnt_adv     = (tick_en && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;
  assign accept      = evt_valid & evt_ready;
  assign active      = (state != IDLE);

  // Lowest-index priority encoder over presses not already being tracked
  always_comb begin
    sel_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (other_press[i]) sel_ch = CH_W'(i);
    end
  end

  // Next-state logic: new press wins, then release, then delay/period expiry
  always_comb begin
    next_state = state;
    next_ch    = cur_ch;
    cnt_next   = cnt;
    emit       = 1'b0;
    if (|other_press) begin
      next_ch    = sel_ch;
      next_state = HOLD_ENTRY;
      cnt_next   = '0;
      emit       = 1'b1;
    end else if (state == IDLE) begin
      cnt_next = '0;
    end else if (!lvl[cur_ch]) begin
      next_state = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        HOLD_DELAY: begin
          cnt_next = cnt_adv;
          if (cnt_adv >= CNT_W'(REPEAT_DELAY)) begin
            next_state = HOLD_REPEAT;
            cnt_next   = '0;
            emit       = 1'b1;
          end
        end
        HOLD_REPEAT: begin
          cnt_next = cnt_adv;
          if (cnt_adv >= CNT_W'(REPEAT_PERIOD)) begin
            cnt_next = '0;
            emit     = 1'b1;
          end
        end
        default: cnt_next = '0;
      endcase
    end
  end

  // FSM state, tracked channel and tick counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      cur_ch <= '0;
      cnt    <= '0;
    end else begin
      state  <= next_state;
      cur_ch <= next_ch;
      cnt    <= cnt_next;
    end
  end

  // One-entry event buffer: load when free or draining, otherwise count a drop
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      evt_valid <= 1'b0;
      evt_dir   <= '0;
      drop_cnt  <= '0;
    end else if (emit && (!evt_valid || accept)) begin
      evt_valid <= 1'b1;
      evt_dir   <= N_CH'(1) << next_ch;
    end else if (emit) begin
      if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
    end else if (accept) begin
      evt_valid <= 1'b0;
      evt_dir   <= '0;
    end
  end

endmodule

// File: tb/tb_move_event_gen.sv
// Testbench for move_event_gen: directed scenarios with fixed expectations plus
// a randomized run compared against a behavioural model of the press rules.
module tb_move_event_gen;
  import move_event_gen_pkg::*;

  localparam int DLY = 4;
  localparam int PER = 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tick_en = 1'b1;
  logic       evt_ready = 1'b1;
  logic [3:0] kbd_in = 4'b0000;
  logic [3:0] btn_in = 4'b1111;
  logic [3:0] ch_mask = 4'b1111;
  logic       evt_valid, active, evt_valid0, active0;
  logic [3:0] evt_dir, evt_dir0;
  logic [7:0] drop_cnt, drop_cnt0;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  move_event_gen #(.N_CH(4), .CNT_W(16), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER),
                   .REPEAT_EN(1), .DROP_W(8)) dut (
    .clk(clk), .rstn(rstn), .tick_en(tick_en), .kbd_in(kbd_in), .btn_in(btn_in),
    .ch_mask(ch_mask), .evt_valid(evt_valid), .evt_dir(evt_dir), .evt_ready(evt_ready),
    .active(active), .drop_cnt(drop_cnt));

  move_event_gen #(.N_CH(4), .CNT_W(16), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER),
                   .REPEAT_EN(0), .DROP_W(8)) dut0 (
    .clk(clk), .rstn(rstn), .tick_en(tick_en), .kbd_in(kbd_in), .btn_in(btn_in),
    .ch_mask(ch_mask), .evt_valid(evt_valid0), .evt_dir(evt_dir0), .evt_ready(evt_ready),
    .active(active0), .drop_cnt(drop_cnt0));

  // Behavioural model: pin history, tracked channel as an integer, ticks since last event
  typedef struct {
    logic [3:0] k1, k2, b1, b2;
    logic [3:0] lvl_prev;
    int         edges;
    int         ch;
    int         since;
    bit         first;
    bit         pend;
    logic [3:0] pdir;
    int         drop;
  } model_t;

  model_t m1, m0;

  function automatic int lowest(logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic model_t model_reset();
    model_t r;
    r.k1 = '0; r.k2 = '0; r.b1 = '1; r.b2 = '1; r.lvl_prev = '1;
    r.edges = 0; r.ch = -1; r.since = 0; r.first = 1'b0;
    r.pend = 1'b0; r.pdir = '0; r.drop = 0;
    return r;
  endfunction

  function automatic model_t step(model_t m, bit rep_en, logic [3:0] kbd, logic [3:0] btn,
                                  logic [3:0] mask, bit tick, bit ready);
    model_t n = m;
    logic [3:0] lvl, press, other;
    bit emit = 1'b0;
    int ech = 0;
    bit acc;
    lvl   = (m.k2 | ~m.b2) & mask;
    press = (m.edges >= 3) ? (lvl & ~m.lvl_prev) : 4'b0000;
    if (m.ch < 0) begin
      if (press != 0) begin
        ech = lowest(press); n.ch = ech; emit = 1'b1; n.since = 0; n.first = 1'b1;
      end
    end else begin
      other = press & ~(4'b0001 << m.ch);
      if (other != 0) begin
        ech = lowest(other); n.ch = ech; emit = 1'b1; n.since = 0; n.first = 1'b1;
      end else if (!lvl[m.ch]) begin
        n.ch = -1;
      end else if (rep_en) begin
        if (tick) n.since = m.since + 1;
        if (n.since >= (m.first ? DLY : PER)) begin
          emit = 1'b1; ech = m.ch; n.since = 0; n.first = 1'b0;
        end
      end
    end
    acc = m.pend && ready;
    if (emit) begin
      if (!m.pend || acc) begin
        n.pend = 1'b1; n.pdir = 4'b0001 << ech;
      end else if (m.drop < 255) begin
        n.drop = m.drop + 1;
      end
    end else if (acc) begin
      n.pend = 1'b0;
    end
    n.k2 = m.k1; n.k1 = kbd; n.b2 = m.b1; n.b1 = btn; n.lvl_prev = lvl;
    n.edges = (m.edges < 100) ? m.edges + 1 : m.edges;
    return n;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m1 <= model_reset();
      m0 <= model_reset();
    end else begin
      m1 <= step(m1, 1'b1, kbd_in, btn_in, ch_mask, tick_en, evt_ready);
      m0 <= step(m0, 1'b0, kbd_in, btn_in, ch_mask, tick_en, evt_ready);
    end
  end

  task automatic do_reset();
    kbd_in = '0; btn_in = '1; ch_mask = '1; evt_ready = 1'b1; tick_en = 1'b1;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    @(negedge clk);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", evt_valid); end
    total++; if (evt_dir !== 4'b0000) begin bad++; $display("[TB] FAIL reset_dir got=%b want=0000", evt_dir); end
    total++; if (active !== 1'b0) begin bad++; $display("[TB] FAIL reset_active got=%b want=0", active); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("[TB] FAIL reset_drop got=%0d want=0", drop_cnt); end
    total++; if (evt_valid0 !== 1'b0 || active0 !== 1'b0) begin bad++; $display("[TB] FAIL reset_dut0 got=%b%b want=00", evt_valid0, active0); end
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (evt_valid !== 1'b0 || active !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_idle got=%b%b want=00", evt_valid, active); end
  endtask

  task automatic test_single_tap();
    int nev = 0;
    int first = -1;
    logic [3:0] dir = '0;
    kbd_in = 4'b0001 << UP;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(negedge clk);
      if (evt_valid) begin
        nev++;
        if (first < 0) begin first = cyc; dir = evt_dir; end
      end
      if (cyc == 3) kbd_in = '0;
    end
    total++; if (nev != 1) begin bad++; $display("[TB] FAIL tap_count got=%0d want=1", nev); end
    total++; if (first != 3) begin bad++; $display("[TB] FAIL tap_latency got=%0d want=3", first); end
    total++; if (dir !== 4'b0100) begin bad++; $display("[TB] FAIL tap_dir got=%b want=0100", dir); end
    total++; if (active !== 1'b0) begin bad++; $display("[TB] FAIL tap_active got=%b want=0", active); end
  endtask

  task automatic test_hold();
    bit exp;
    btn_in = ~(4'b0001 << LEFT);
    for (int cyc = 1; cyc <= 35; cyc++) begin
      @(negedge clk);
      exp = (cyc == 3) || (cyc >= 7 && cyc <= 21 && (cyc % 2) == 1);
      total++; if (evt_valid !== exp) begin bad++; $display("[TB] FAIL hold_valid cyc=%0d got=%b want=%b", cyc, evt_valid, exp); end
      if (exp) begin
        total++; if (evt_dir !== 4'b0001) begin bad++; $display("[TB] FAIL hold_dir cyc=%0d got=%b want=0001", cyc, evt_dir); end
      end
      if (cyc == 20) btn_in = '1;
    end
    total++; if (active !== 1'b0) begin bad++; $display("[TB] FAIL hold_active got=%b want=0", active); end
  endtask

  task automatic test_preempt();
    bit exp;
    logic [3:0] exp_dir;
    kbd_in = 4'b1010;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      exp     = (cyc == 3) || (cyc == 7) || (cyc == 8) || (cyc == 12) || (cyc == 14);
      exp_dir = (cyc < 8) ? 4'b0010 : 4'b0001;
      total++; if (evt_valid !== exp) begin bad++; $display("[TB] FAIL preempt_valid cyc=%0d got=%b want=%b", cyc, evt_valid, exp); end
      if (exp) begin
        total++; if (evt_dir !== exp_dir) begin bad++; $display("[TB] FAIL preempt_dir cyc=%0d got=%b want=%b", cyc, evt_dir, exp_dir); end
      end
      if (cyc == 5) kbd_in = 4'b1011;
    end
    kbd_in = '0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_backpressure();
    do_reset();
    evt_ready = 1'b0;
    kbd_in = 4'b0001 << RIGHT;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(negedge clk);
      if (cyc >= 3 && cyc <= 10) begin
        total++; if (evt_valid !== 1'b1 || evt_dir !== 4'b1000) begin bad++; $display("[TB] FAIL bp_hold cyc=%0d got=%b/%b want=1/1000", cyc, evt_valid, evt_dir); end
      end
      if (cyc == 8) kbd_in = '0;
      if (cyc == 10) begin
        total++; if (drop_cnt !== 8'd2) begin bad++; $display("[TB] FAIL bp_drop got=%0d want=2", drop_cnt); end
        evt_ready = 1'b1;
      end
      if (cyc == 11) begin
        total++; if (evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drain got=%b want=0", evt_valid); end
        total++; if (drop_cnt !== 8'd2) begin bad++; $display("[TB] FAIL bp_drop_keep got=%0d want=2", drop_cnt); end
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    int nev = 0;
    do_reset();
    evt_ready = 1'b0;
    kbd_in = 4'b0001;
    repeat (10) @(negedge clk);
    total++; if (evt_valid !== 1'b1 || drop_cnt !== 8'd2) begin bad++; $display("[TB] FAIL rst_pre got=%b/%0d want=1/2", evt_valid, drop_cnt); end
    #2 rstn = 1'b0;
    #1;
    total++; if (evt_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_async_valid got=%b want=0", evt_valid); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("[TB] FAIL rst_async_drop got=%0d want=0", drop_cnt); end
    total++; if (active !== 1'b0) begin bad++; $display("[TB] FAIL rst_async_active got=%b want=0", active); end
    @(negedge clk);
    rstn = 1'b1;
    evt_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (evt_valid) nev++;
    end
    total++; if (nev != 0) begin bad++; $display("[TB] FAIL rst_held_events got=%0d want=0", nev); end
    kbd_in = '0;
    repeat (4) @(negedge clk);
    kbd_in = 4'b0001;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      if (cyc == 3) begin
        total++; if (evt_valid !== 1'b1 || evt_dir !== 4'b0001) begin bad++; $display("[TB] FAIL rst_repress got=%b/%b want=1/0001", evt_valid, evt_dir); end
      end
    end
    kbd_in = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_no_repeat_mask();
    int nev0 = 0;
    logic [3:0] dir0 = '0;
    do_reset();
    btn_in = ~(4'b0001 << UP);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (evt_valid0) begin nev0++; dir0 = evt_dir0; end
    end
    total++; if (nev0 != 1) begin bad++; $display("[TB] FAIL norep_count got=%0d want=1", nev0); end
    total++; if (dir0 !== 4'b0100) begin bad++; $display("[TB] FAIL norep_dir got=%b want=0100", dir0); end
    total++; if (active0 !== 1'b1) begin bad++; $display("[TB] FAIL norep_active got=%b want=1", active0); end
    ch_mask = 4'b1011;
    @(negedge clk);
    total++; if (active0 !== 1'b0 || evt_valid0 !== 1'b0) begin bad++; $display("[TB] FAIL mask_release0 got=%b/%b want=0/0", active0, evt_valid0); end
    total++; if (active !== 1'b0) begin bad++; $display("[TB] FAIL mask_release got=%b want=0", active); end
    btn_in = '1;
    ch_mask = '1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      total++; if (evt_valid !== m1.pend) begin bad++; $display("[TB] FAIL rnd_valid cyc=%0d got=%b want=%b", cyc, evt_valid, m1.pend); end
      if (m1.pend) begin
        total++; if (evt_dir !== m1.pdir) begin bad++; $display("[TB] FAIL rnd_dir cyc=%0d got=%b want=%b", cyc, evt_dir, m1.pdir); end
      end
      total++; if (active !== (m1.ch >= 0)) begin bad++; $display("[TB] FAIL rnd_active cyc=%0d got=%b want=%b", cyc, active, (m1.ch >= 0)); end
      total++; if (drop_cnt !== 8'(m1.drop)) begin bad++; $display("[TB] FAIL rnd_drop cyc=%0d got=%0d want=%0d", cyc, drop_cnt, m1.drop); end
      total++; if (evt_valid0 !== m0.pend) begin bad++; $display("[TB] FAIL rnd0_valid cyc=%0d got=%b want=%b", cyc, evt_valid0, m0.pend); end
      if (m0.pend) begin
        total++; if (evt_dir0 !== m0.pdir) begin bad++; $display("[TB] FAIL rnd0_dir cyc=%0d got=%b want=%b", cyc, evt_dir0, m0.pdir); end
      end
      total++; if (active0 !== (m0.ch >= 0)) begin bad++; $display("[TB] FAIL rnd0_active cyc=%0d got=%b want=%b", cyc, active0, (m0.ch >= 0)); end
      total++; if (drop_cnt0 !== 8'(m0.drop)) begin bad++; $display("[TB] FAIL rnd0_drop cyc=%0d got=%0d want=%0d", cyc, drop_cnt0, m0.drop); end
      if ($urandom_range(0, 5) == 0) kbd_in = 4'($urandom);
      if ($urandom_range(0, 7) == 0) btn_in = 4'($urandom) | 4'($urandom);
      if ($urandom_range(0, 29) == 0) ch_mask = ($urandom_range(0, 1) == 1) ? 4'b1111 : 4'($urandom);
      evt_ready = ($urandom_range(0, 3) != 0);
      tick_en   = ($urandom_range(0, 4) != 0);
    end
  endtask

  initial begin
    $display("[TB] starting move_event_gen bench");
    test_reset();
    test_single_tap();
    test_hold();
    test_preempt();
    test_backpressure();
    test_reset_mid_hold();
    test_no_repeat_mask();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
